rom_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer that shares one synchronous single-port ROM (1-cycle registered read) between several clients. Each client requests a burst of consecutive words. The arbiter grants one client at a time and drives the ROM address once per cycle. It routes the ROM output back to the owning client with a per-client valid strobe. It sits between sprite, font and palette readers and a shared ROM instance.

---
 rtl/rom_arb_pkg.sv | 27 ++
 rtl/rom_arbiter_rr_pick.sv | 37 +++
 rtl/rom_arbiter.sv | 151 +++++++++++++++
 tb/tb_rom_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and helpers for the ROM arbiter family.
//   state_t   : burst sequencer states (IDLE / BURST)
//   next_addr : address increment with wrap at an arbitrary (non power-of-two)
//               ROM depth
// -----------------------------------------------------------------------------
package rom_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Next sequential ROM address; wraps from depth-1 back to 0.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [31:0] depth);
        logic [31:0] nxt;
        if (addr == depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = addr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// index ptr and wrapping upward; the first set bit wins.
// Ports:
//   req [N-1:0]        : request vector
//   ptr [log2(N)-1:0]  : highest-priority index for this search
//   win [log2(N)-1:0]  : winning index (0 when no request)
//   any                : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] win,
    output logic                 any
);

    localparam int IDXW = $clog2(N);

    // Walk offsets from far to near so the nearest set request (smallest
    // offset from ptr) is the last assignment and therefore wins.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                win = IDXW'((int'(ptr) + k) % N);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Round-robin arbiter and burst sequencer sharing one synchronous ROM
// (1-cycle registered read) between CLIENTS requesters.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req      [CLIENTS]  : per-client request level (held until ack)
//   req_addr            : per-client start address, ADDRW bits each
//   req_len             : per-client burst length minus one, LENW bits each
//   ack      [CLIENTS]  : one-cycle accept pulse (registered)
//   busy                : a burst is being issued (registered)
//   rsp_valid[CLIENTS]  : rsp_data holds a word for that client (registered)
//   rsp_data [WIDTH]    : ROM data passed straight through
//   rom_addr [ADDRW]    : registered ROM address
//   rom_data [WIDTH]    : ROM output, valid one cycle after rom_addr
// -----------------------------------------------------------------------------
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter  int CLIENTS = 4,
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 256,
    parameter  int MAXLEN  = 16,
    localparam int ADDRW   = $clog2(DEPTH),
    localparam int LENW    = $clog2(MAXLEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CLIENTS-1:0]       req,
    input  logic [CLIENTS*ADDRW-1:0] req_addr,
    input  logic [CLIENTS*LENW-1:0]  req_len,
    output logic [CLIENTS-1:0]       ack,
    output logic                     busy,
    output logic [CLIENTS-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ADDRW-1:0]         rom_addr,
    input  logic [WIDTH-1:0]         rom_data
);

    localparam int                 PTRW = $clog2(CLIENTS);
    localparam logic [CLIENTS-1:0] ONE  = CLIENTS'(1);

    state_t               r_state;
    logic [PTRW-1:0]      r_ptr;
    logic [PTRW-1:0]      r_owner;
    logic [LENW-1:0]      r_remain;
    logic [ADDRW-1:0]     r_cur_addr;
    logic [ADDRW-1:0]     r_rom_addr;
    logic [CLIENTS-1:0]   r_ack;
    logic                 r_busy;
    logic                 r_valid;
    logic [CLIENTS-1:0]   r_rsp_valid;

    logic [PTRW-1:0]      w_win;
    logic                 w_any;
    logic [ADDRW-1:0]     w_start_addr;
    logic [LENW-1:0]      w_start_len;

    rr_pick #(
        .N   (CLIENTS)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .win (w_win),
        .any (w_any)
    );

    assign w_start_addr = req_addr[int'(w_win) * ADDRW +: ADDRW];
    assign w_start_len  = req_len[int'(w_win) * LENW +: LENW];

    // Burst sequencer: grant in IDLE, then issue one address per cycle.
    // r_cur_addr always holds the address to issue on the next BURST cycle,
    // so the start address goes straight to rom_addr at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_remain   <= '0;
            r_cur_addr <= '0;
            r_rom_addr <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_win;
                        r_remain   <= w_start_len;
                        r_rom_addr <= w_start_addr;
                        r_cur_addr <= ADDRW'(next_addr(32'(w_start_addr), 32'(DEPTH)));
                        r_ack      <= ONE << w_win;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= BURST;
                    end else begin
                        r_ack      <= '0;
                        r_valid    <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                BURST: begin
                    r_ack <= '0;
                    if (r_remain == '0) begin
                        // Word on rom_addr was the last; previous owner drops
                        // to lowest priority for the next search.
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        if (r_owner == PTRW'(CLIENTS - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= r_owner + PTRW'(1);
                        end
                        r_state <= IDLE;
                    end else begin
                        r_rom_addr <= r_cur_addr;
                        r_cur_addr <= ADDRW'(next_addr(32'(r_cur_addr), 32'(DEPTH)));
                        r_remain   <= r_remain - LENW'(1);
                        r_valid    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Return path: delay (issue valid, owner) by one cycle to line up with
    // the ROM's registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
        end else if (r_valid) begin
            r_rsp_valid <= ONE << r_owner;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
// Self-checking bench for rom_arbiter (CLIENTS=4, WIDTH=8, DEPTH=200,
// MAXLEN=16). A transaction-level model predicts, per cycle, the expected
// ack / busy / rom_addr / rsp_valid / rsp_data from each grant decision.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

    localparam int C    = 4;
    localparam int W    = 8;
    localparam int D    = 200;
    localparam int M    = 16;
    localparam int AW   = 8;
    localparam int LW   = 4;
    localparam int NCYC = 2048;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [C-1:0]      req = '0;
    logic [C*AW-1:0]   req_addr = '0;
    logic [C*LW-1:0]   req_len = '0;
    logic [C-1:0]      ack;
    logic              busy;
    logic [C-1:0]      rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [AW-1:0]     rom_addr;
    logic [W-1:0]      rom_data = '0;

    rom_arbiter #(
        .CLIENTS (C),
        .WIDTH   (W),
        .DEPTH   (D),
        .MAXLEN  (M)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .ack       (ack),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;

    // Shared ROM, ROM[n] = n, one-cycle registered read.
    logic [W-1:0] mem [D];
    initial begin
        for (int n = 0; n < D; n++) mem[n] = W'(n);
    end
    always @(posedge clk) rom_data <= mem[rom_addr];

    // Expected per-cycle outputs.
    logic [C-1:0]  e_ack  [NCYC];
    logic [C-1:0]  e_rv   [NCYC];
    logic          e_busy [NCYC];
    logic          e_achk [NCYC];
    logic [AW-1:0] e_addr [NCYC];
    logic [W-1:0]  e_data [NCYC];

    // Client driver state.
    logic pend [C];
    int   ca [C];
    int   cl [C];
    int   prob [C];
    int   fixlen;
    int   rv_cnt [C];

    int cyc, free_cyc, last_owner;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCYC; i++) begin
            e_ack[i] = '0; e_rv[i] = '0; e_busy[i] = 1'b0;
            e_achk[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
        end
        e_achk[0] = 1'b1;
        for (int i = 0; i < C; i++) begin
            pend[i] = 1'b0; ca[i] = 0; cl[i] = 0; prob[i] = 0; rv_cnt[i] = 0;
        end
        fixlen = -1;
        cyc = 0;
        free_cyc = 0;
        last_owner = -1;
    endtask

    // One cycle: check outputs, update clients, predict any new grant.
    task automatic cycle_body();
        int w, l, a, idx;
        bit any_p;
        check_eq("ack", 32'(ack), 32'(e_ack[cyc]));
        check_eq("busy", 32'(busy), 32'(e_busy[cyc]));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rv[cyc]));
        if (e_achk[cyc]) check_eq("rom_addr", 32'(rom_addr), 32'(e_addr[cyc]));
        if (e_rv[cyc] != '0) check_eq("rsp_data", 32'(rsp_data), 32'(e_data[cyc]));
        for (int i = 0; i < C; i++) if (rsp_valid[i]) rv_cnt[i]++;

        for (int i = 0; i < C; i++) begin
            if (e_ack[cyc][i]) begin
                pend[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(99) < prob[i]) begin
                pend[i] = 1'b1;
                ca[i] = $urandom_range(D - 1);
                cl[i] = (fixlen >= 0) ? fixlen : $urandom_range(M - 1);
            end
            req[i] = pend[i];
            req_addr[i*AW +: AW] = AW'(ca[i]);
            req_len[i*LW +: LW] = LW'(cl[i]);
        end

        any_p = 1'b0;
        for (int i = 0; i < C; i++) if (pend[i]) any_p = 1'b1;
        if (cyc >= free_cyc && any_p) begin
            w = -1;
            for (int k = 1; k <= C; k++) begin
                idx = (last_owner + k + C) % C;
                if (w < 0 && pend[idx]) w = idx;
            end
            l = cl[w] + 1;
            e_ack[cyc + 1][w] = 1'b1;
            for (int k = 0; k < l; k++) begin
                a = (ca[w] + k) % D;
                e_busy[cyc + 1 + k] = 1'b1;
                e_achk[cyc + 1 + k] = 1'b1;
                e_addr[cyc + 1 + k] = AW'(a);
                e_rv[cyc + 2 + k][w] = 1'b1;
                e_data[cyc + 2 + k] = mem[a];
            end
            free_cyc = cyc + l + 1;
            last_owner = w;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            cycle_body();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ack"}, 32'(ack), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        model_clear();
        #1;
        check_outputs_zero("pwrup");

        // Single burst: client 2, addr 0x10, 4 words.
        do_reset();
        pend[2] = 1'b1; ca[2] = 16; cl[2] = 3;
        cycle_body();
        run(8);

        // Contention: all clients, single-word bursts, from reset.
        do_reset();
        for (int i = 0; i < C; i++) begin
            pend[i] = 1'b1; ca[i] = i * 10 + 5; cl[i] = 0;
        end
        cycle_body();
        run(10);

        // Fairness: clients 0 and 1 request continuously.
        do_reset();
        prob[0] = 100; prob[1] = 100; fixlen = 1;
        cycle_body();
        run(60);

        // Address wrap at DEPTH-1.
        do_reset();
        pend[1] = 1'b1; ca[1] = 198; cl[1] = 3;
        cycle_body();
        run(8);

        // Maximum burst length.
        do_reset();
        pend[3] = 1'b1; ca[3] = 190; cl[3] = M - 1;
        cycle_body();
        run(20);
        check_eq("maxlen_pulses", 32'(rv_cnt[3]), 32'(M));

        // Mid-burst reset, then pointer restarts at client 0.
        do_reset();
        pend[2] = 1'b1; ca[2] = 50; cl[2] = 7;
        cycle_body();
        run(3);
        #2;
        rst_n = 1'b0;
        req = '0;
        #1;
        check_outputs_zero("mrst");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("mrst_rsp_valid_hold", 32'(rsp_valid), 32'd0);
            check_eq("mrst_busy_hold", 32'(busy), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        pend[1] = 1'b1; ca[1] = 20; cl[1] = 1;
        pend[3] = 1'b1; ca[3] = 30; cl[3] = 1;
        cycle_body();
        run(8);

        // Randomized traffic from all clients.
        do_reset();
        for (int i = 0; i < C; i++) prob[i] = 25;
        cycle_body();
        run(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
